// File: rtl/fir_out_packer_if.sv
// fir_out_packer_if: FIR result input (no backpressure) and AXI4-Stream output of the packer.
interface fir_out_packer_if #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 16
);
   logic                 s_tvalid;
   logic [IN_WIDTH-1:0]  s_tdata;
   logic                 m_tvalid;
   logic                 m_tready;
   logic [OUT_WIDTH-1:0] m_tdata;
   logic                 m_tlast;
   modport master (input s_tvalid, s_tdata, m_tready, output m_tvalid, m_tdata, m_tlast);
   modport slave (output s_tvalid, s_tdata, m_tready, input m_tvalid, m_tdata, m_tlast);
endinterface

// File: rtl/fir_out_packer.sv
// fir_out_packer: saturates FIR results to Q1.15 and streams them from a FWFT FIFO
// as AXI4-Stream packets of PKT_LEN samples, with sticky overflow and saturation count.
module fir_out_packer #(
   parameter int IN_WIDTH   = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int PKT_LEN    = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   fir_out_packer_if.master              bus,
   input  logic                          clr_ovf,
   output logic                          overflow,
   output logic [15:0]                   sat_count,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(PKT_LEN);
   localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
   logic                          w_hi, w_lo, w_sat;
   logic [OUT_WIDTH-1:0]          w_sat_d;
   logic                          w_vld, w_pop, w_full, w_wr, w_drop, w_tag;
   logic                          r_sat_v;
   logic [OUT_WIDTH-1:0]          r_sat_d;
   logic [15:0]                   r_sat_cnt;
   logic                          r_ovf;
   logic [AW-1:0]                 r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]                 r_level;
   logic [CW-1:0]                 r_pkt;
   logic [OUT_WIDTH:0]            r_mem [FIFO_DEPTH];
   // Out of range iff the bits above the Q1.15 sign disagree with the input sign.
   always_comb begin
      w_hi    = !bus.s_tdata[IN_WIDTH-1] && (|bus.s_tdata[IN_WIDTH-2:OUT_WIDTH-1]);
      w_lo    = bus.s_tdata[IN_WIDTH-1] && !(&bus.s_tdata[IN_WIDTH-2:OUT_WIDTH-1]);
      w_sat   = w_hi || w_lo;
      w_sat_d = w_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                w_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : bus.s_tdata[OUT_WIDTH-1:0];
   end
   always_comb begin
      w_vld  = r_level != '0;
      w_pop  = w_vld && bus.m_tready;
      w_full = r_level == FULL;
      w_wr   = r_sat_v && (!w_full || w_pop);
      w_drop = r_sat_v && w_full && !w_pop;
      w_tag  = r_pkt == LAST;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_v <= 1'b0;
         r_sat_d <= '0;
      end else begin
         r_sat_v <= bus.s_tvalid;
         r_sat_d <= w_sat_d;
      end
   end
   // A new event in the clearing cycle wins over clr_ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (bus.s_tvalid && w_sat)
            r_sat_cnt <= clr_ovf ? 16'd1 : r_sat_cnt + {15'd0, ~&r_sat_cnt};
         else if (clr_ovf)
            r_sat_cnt <= '0;
         if (w_drop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end
   // Packet counter moves only on accepted writes, so drops never shorten a packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_pkt    <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_pkt    <= w_tag ? '0 : r_pkt + CW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      end
   end
   always_ff @(posedge clk)
      if (w_wr)
         r_mem[r_wr_ptr] <= {w_tag, r_sat_d};
   assign bus.m_tvalid = w_vld;
   assign bus.m_tdata  = w_vld ? r_mem[r_rd_ptr][OUT_WIDTH-1:0] : '0;
   assign bus.m_tlast  = w_vld && r_mem[r_rd_ptr][OUT_WIDTH];
   assign overflow     = r_ovf;
   assign sat_count    = r_sat_cnt;
   assign level        = r_level;
endmodule

// File: tb/tb_fir_out_packer.sv
// tb_fir_out_packer: table-driven vectors plus a reference FIFO model feeding a scoreboard.
module tb_fir_out_packer;
   localparam int PKT   = 4;
   localparam int DEPTH = 16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_ovf = 1'b0;
   logic        overflow;
   logic [15:0] sat_count;
   logic [4:0]  level;
   fir_out_packer_if #(.IN_WIDTH(32), .OUT_WIDTH(16)) bus ();
   fir_out_packer #(.IN_WIDTH(32), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH), .PKT_LEN(PKT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .clr_ovf(clr_ovf),
      .overflow(overflow), .sat_count(sat_count), .level(level)
   );
   always #5 clk = ~clk;
   int          n_chk = 0, n_fail = 0, n_hs = 0, n_last = 0;
   logic [16:0] sb [$];
   logic [15:0] cur_exp = '0, pd = '0, msat = '0;
   logic        pv = 1'b0, movf = 1'b0, chk_en = 1'b0;
   int          mlev = 0, mpkt = 0;
   typedef struct {
      logic [31:0] din;
      logic [15:0] dout;
   } vec_t;
   vec_t tab [4];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic is_sat(input logic [31:0] x);
      return $signed(x) > 32767 || $signed(x) < -32768;
   endfunction
   function automatic logic [15:0] sat16(input logic [31:0] x);
      if ($signed(x) > 32767) return 16'h7FFF;
      if ($signed(x) < -32768) return 16'h8000;
      return x[15:0];
   endfunction
   // Reference model: evaluates at negedge what the coming posedge will do.
   always @(negedge clk) begin
      logic        pop, wr;
      logic [16:0] h;
      if (chk_en) begin
         check("level", 32'(level), 32'(mlev));
         check("m_tvalid", 32'(bus.m_tvalid), 32'(mlev != 0));
         check("overflow", 32'(overflow), 32'(movf));
         check("sat_count", 32'(sat_count), 32'(msat));
      end
      if (rst) begin
         sb.delete();
         mlev = 0; mpkt = 0; pv = 1'b0; movf = 1'b0; msat = '0; chk_en = 1'b1;
      end else begin
         pop = mlev != 0 && bus.m_tready;
         if (pop) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               h = sb.pop_front();
               check("sb_data", 32'(bus.m_tdata), 32'(h[15:0]));
               check("sb_last", 32'(bus.m_tlast), 32'(h[16]));
            end
            n_hs++;
            if (bus.m_tlast) n_last++;
         end
         wr = pv && (mlev < DEPTH || pop);
         if (wr) begin
            sb.push_back({mpkt == PKT - 1, pd});
            mpkt = (mpkt == PKT - 1) ? 0 : mpkt + 1;
         end
         if (pv && !wr) movf = 1'b1;
         else if (clr_ovf) movf = 1'b0;
         if (bus.s_tvalid && is_sat(bus.s_tdata))
            msat = clr_ovf ? 16'd1 : (msat == 16'hFFFF ? msat : msat + 16'd1);
         else if (clr_ovf)
            msat = '0;
         mlev = mlev + int'(wr) - int'(pop);
         pv = bus.s_tvalid;
         pd = cur_exp;
      end
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input logic [31:0] x, input logic [15:0] e);
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = x;
      cur_exp      = e;
      cyc();
      bus.s_tvalid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      bus.m_tready = 1'b1;
      cyc();
      cyc();
      while (level != 0 && n < 100) begin
         cyc();
         n++;
      end
      check("drain_timeout", 32'(n < 100), 32'd1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int h0, l0;
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = '0;
      bus.m_tready = 1'b0;
      tab[0] = '{32'h00001234, 16'h1234};
      tab[1] = '{32'h00010000, 16'h7FFF};
      tab[2] = '{32'hFFFE0000, 16'h8000};
      tab[3] = '{32'hFFFF8000, 16'h8000};
      repeat (2) cyc();
      rst = 1'b0;
      check("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
      check("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
      check("rst_m_tlast", 32'(bus.m_tlast), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_sat_count", 32'(sat_count), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      // Packetisation: 12 back-to-back samples, tlast on 4, 8, 12.
      bus.m_tready = 1'b1;
      h0 = n_hs; l0 = n_last;
      for (int i = 0; i < 12; i++) begin
         put(32'(i * 37 + 5), sat16(32'(i * 37 + 5)));
         check("pkt_level_le2", 32'(level <= 2), 32'd1);
      end
      drain();
      check("pkt_count", 32'(n_hs - h0), 32'd12);
      check("pkt_tlast_count", 32'(n_last - l0), 32'd3);
      // Saturation table: each output visible two cycles after its input.
      for (int i = 0; i < 5; i++) begin
         if (i < 4) put(tab[i].din, tab[i].dout);
         else cyc();
         if (i >= 1) begin
            check("sat_latency_valid", 32'(bus.m_tvalid), 32'd1);
            check("sat_data", 32'(bus.m_tdata), 32'(tab[i-1].dout));
         end
      end
      drain();
      check("sat_count_total", 32'(sat_count), 32'd2);
      // Backpressure: fill to 16 with head held stable, then drain in 16 cycles.
      bus.m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         put(32'h100 + 32'(i), 16'h100 + 16'(i));
         if (i >= 2) check("bp_hold", 32'(bus.m_tdata), 32'h100);
      end
      cyc();
      cyc();
      check("bp_level", 32'(level), 32'd16);
      check("bp_valid", 32'(bus.m_tvalid), 32'd1);
      check("bp_head", 32'(bus.m_tdata), 32'h100);
      check("bp_overflow", 32'(overflow), 32'd0);
      bus.m_tready = 1'b1;
      repeat (15) cyc();
      check("bp_drain15", 32'(level), 32'd1);
      cyc();
      check("bp_drain16", 32'(level), 32'd0);
      // Overflow: three extra samples into a full FIFO are dropped.
      bus.m_tready = 1'b0;
      h0 = n_hs;
      for (int i = 0; i < 16; i++) put(32'h200 + 32'(i), 16'h200 + 16'(i));
      for (int i = 0; i < 3; i++) put(32'h2F0 + 32'(i), 16'h2F0 + 16'(i));
      cyc();
      cyc();
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_level", 32'(level), 32'd16);
      clr_ovf = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      check("ovf_clear", 32'(overflow), 32'd0);
      drain();
      check("ovf_drained", 32'(n_hs - h0), 32'd16);
      // Full FIFO with simultaneous write and pop keeps level at 16.
      bus.m_tready = 1'b0;
      h0 = n_hs;
      for (int i = 0; i < 16; i++) put(32'h300 + 32'(i), 16'h300 + 16'(i));
      put(32'h400, 16'h400);
      bus.m_tready = 1'b1;
      for (int i = 1; i < 20; i++) begin
         put(32'h400 + 32'(i), 16'h400 + 16'(i));
         check("full_rw_level", 32'(level), 32'd16);
         check("full_rw_overflow", 32'(overflow), 32'd0);
      end
      drain();
      check("full_rw_count", 32'(n_hs - h0), 32'd36);
      // Reset mid-packet with level 7 and a sample in stage 1.
      bus.m_tready = 1'b0;
      for (int i = 0; i < 8; i++) put(32'h500 + 32'(i), 16'h500 + 16'(i));
      check("rst_pre_level", 32'(level), 32'd7);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rst_mid_valid", 32'(bus.m_tvalid), 32'd0);
      check("rst_mid_level", 32'(level), 32'd0);
      cyc();
      check("rst_stage1_flushed", 32'(level), 32'd0);
      h0 = n_hs; l0 = n_last;
      bus.m_tready = 1'b1;
      for (int i = 0; i < 8; i++) put(32'h600 + 32'(i), 16'h600 + 16'(i));
      drain();
      check("rst_pkt_count", 32'(n_hs - h0), 32'd8);
      check("rst_pkt_tlast", 32'(n_last - l0), 32'd2);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
